// File: rtl/stopwatch_counter.sv
// -----------------------------------------------------------------------------
// stopwatch_counter
//
// Time-keeping datapath for the stopwatch. A prescaler divides clk down to a
// centisecond rate, and each prescaler roll-over advances a four-digit BCD
// cascade SS.CC (seconds 00-59, centiseconds 00-99). The upstream control FSM
// decides clear/run/hold; this block has no state machine of its own.
//
// Parameters:
//   CLK_FREQ  input clock frequency in Hz
//   TICK_HZ   digit-increment rate in Hz; CLK_FREQ must be an exact multiple
//             of TICK_HZ and CLK_FREQ/TICK_HZ must be >= 2
//
// Ports:
//   clk            in   system clock, rising edge
//   reset          in   synchronous active-high, clears all state
//   init_regs      in   clear prescaler and digits (beats count_enabled)
//   count_enabled  in   advance prescaler / digits
//   time_bcd       out  {sec_tens, sec_ones, csec_tens, csec_ones}
//   tick           out  registered 1-cycle pulse on the edge the digits advance
//   wrapped        out  registered 1-cycle pulse on the 59.99 -> 00.00 edge
//
// Priority on every edge: reset > init_regs > count_enabled > hold.
// -----------------------------------------------------------------------------
module stopwatch_counter #(
    parameter int CLK_FREQ = 100000000,
    parameter int TICK_HZ  = 100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        init_regs,
    input  logic        count_enabled,
    output logic [15:0] time_bcd,
    output logic        tick,
    output logic        wrapped
);

    localparam int DIV = CLK_FREQ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

    logic [PW-1:0] prescaler;
    logic [3:0]    sec_tens;
    logic [3:0]    sec_ones;
    logic [3:0]    csec_tens;
    logic [3:0]    csec_ones;

    // Candidate digit values for a tick edge, with carries between stages.
    logic [3:0] nxt_csec_ones;
    logic [3:0] nxt_csec_tens;
    logic [3:0] nxt_sec_ones;
    logic [3:0] nxt_sec_tens;
    logic       c_csec_ones;
    logic       c_csec_tens;
    logic       c_sec_ones;
    logic       c_sec_tens;
    logic       pre_last;

    // One BCD stage: returns {carry_out, next_digit}. A digit above its
    // maximum is unreachable in normal operation; it is cleared to 0 without
    // carrying so the cascade recovers on the next tick.
    function automatic logic [4:0] bcd_step(input logic [3:0] d,
                                            input logic [3:0] max_d,
                                            input logic       cin);
        logic [4:0] r;
        if (d > max_d) begin
            r = 5'b0_0000;
        end else if (!cin) begin
            r = {1'b0, d};
        end else if (d == max_d) begin
            r = 5'b1_0000;
        end else begin
            r = {1'b0, d + 4'd1};
        end
        return r;
    endfunction

    always_comb begin
        {c_csec_ones, nxt_csec_ones} = bcd_step(csec_ones, 4'd9, 1'b1);
        {c_csec_tens, nxt_csec_tens} = bcd_step(csec_tens, 4'd9, c_csec_ones);
        {c_sec_ones,  nxt_sec_ones}  = bcd_step(sec_ones,  4'd9, c_csec_tens);
        {c_sec_tens,  nxt_sec_tens}  = bcd_step(sec_tens,  4'd5, c_sec_ones);
        pre_last = (prescaler == PRE_LAST);
    end

    always_ff @(posedge clk) begin
        if (reset || init_regs) begin
            // Any partial prescale is discarded; no tick is produced.
            prescaler <= '0;
            sec_tens  <= 4'd0;
            sec_ones  <= 4'd0;
            csec_tens <= 4'd0;
            csec_ones <= 4'd0;
            tick      <= 1'b0;
            wrapped   <= 1'b0;
        end else if (count_enabled) begin
            if (pre_last) begin
                prescaler <= '0;
                sec_tens  <= nxt_sec_tens;
                sec_ones  <= nxt_sec_ones;
                csec_tens <= nxt_csec_tens;
                csec_ones <= nxt_csec_ones;
                tick      <= 1'b1;
                // Carry out of the top stage means we were at 59.99.
                wrapped   <= c_sec_tens;
            end else begin
                prescaler <= prescaler + 1'b1;
                tick      <= 1'b0;
                wrapped   <= 1'b0;
            end
        end else begin
            // Hold: prescaler and digits keep their values so a paused
            // partial centisecond resumes where it left off.
            tick    <= 1'b0;
            wrapped <= 1'b0;
        end
    end

    assign time_bcd = {sec_tens, sec_ones, csec_tens, csec_ones};

endmodule

// File: tb/tb_stopwatch_counter.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_counter
//
// Bench for stopwatch_counter with CLK_FREQ=10, TICK_HZ=1 (DIV=10). The
// reference keeps elapsed time as a plain centisecond count (mod 6000) plus
// the number of enabled edges into the current centisecond, and converts to
// BCD with division and modulo.
// -----------------------------------------------------------------------------
module tb_stopwatch_counter;

    localparam int DIV = 10;

    logic        clk;
    logic        reset;
    logic        init_regs;
    logic        count_enabled;
    logic [15:0] time_bcd;
    logic        tick;
    logic        wrapped;

    int n_cmp;
    int n_err;

    // Reference model state
    int m_cs;
    int m_phase;
    bit m_tick;
    bit m_wrap;

    stopwatch_counter #(
        .CLK_FREQ(10),
        .TICK_HZ (1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .init_regs    (init_regs),
        .count_enabled(count_enabled),
        .time_bcd     (time_bcd),
        .tick         (tick),
        .wrapped      (wrapped)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- model helpers ----------------
    function automatic logic [15:0] to_bcd(input int t);
        int s;
        int c;
        s = t / 100;
        c = t % 100;
        return {4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
    endfunction

    task automatic model_edge(input bit r, input bit i, input bit e);
        if (r || i) begin
            m_cs    = 0;
            m_phase = 0;
            m_tick  = 0;
            m_wrap  = 0;
        end else if (e) begin
            m_phase = m_phase + 1;
            if (m_phase == DIV) begin
                m_phase = 0;
                m_tick  = 1;
                m_wrap  = (m_cs == 5999);
                m_cs    = (m_cs + 1) % 6000;
            end else begin
                m_tick = 0;
                m_wrap = 0;
            end
        end else begin
            m_tick = 0;
            m_wrap = 0;
        end
    endtask

    // ---------------- driver ----------------
    // Inputs change on the falling edge; outputs are sampled 1 time unit
    // after the rising edge.
    task automatic drive(input bit r, input bit i, input bit e);
        @(negedge clk);
        reset         = r;
        init_regs     = i;
        count_enabled = e;
        @(posedge clk);
        model_edge(r, i, e);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        drive(1, 0, 0);
        drive(1, 0, 1);
        n_cmp++;
        if (time_bcd !== 16'h0000) begin
            n_err++;
            $display("FAIL reset_time: got %h want 0000", time_bcd);
        end
        n_cmp++;
        if (tick !== 1'b0 || wrapped !== 1'b0) begin
            n_err++;
            $display("FAIL reset_pulses: got tick=%b wrapped=%b want 0 0", tick, wrapped);
        end
    endtask

    task automatic test_first_tick();
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 1);
            n_cmp++;
            if (tick !== (i == 9)) begin
                n_err++;
                $display("FAIL first_tick_edge%0d: got tick=%b want %b", i + 1, tick, (i == 9));
            end
        end
        n_cmp++;
        if (time_bcd !== 16'h0001) begin
            n_err++;
            $display("FAIL first_tick_time: got %h want 0001", time_bcd);
        end
    endtask

    task automatic test_carry();
        drive(0, 1, 0);
        repeat (95) drive(0, 0, 1);
        n_cmp++;
        if (time_bcd !== 16'h0009) begin
            n_err++;
            $display("FAIL carry_pre: got %h want 0009", time_bcd);
        end
        repeat (5) drive(0, 0, 1);
        n_cmp++;
        if (time_bcd !== 16'h0010) begin
            n_err++;
            $display("FAIL carry_csec: got %h want 0010", time_bcd);
        end
    endtask

    task automatic test_pause();
        bit bad;
        drive(0, 1, 0);
        repeat (4) drive(0, 0, 1);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            drive(0, 0, 0);
            if (time_bcd !== 16'h0000 || tick !== 1'b0) bad = 1;
        end
        n_cmp++;
        if (bad) begin
            n_err++;
            $display("FAIL pause_hold: got %h tick=%b want 0000 tick=0", time_bcd, tick);
        end
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, 1);
            n_cmp++;
            if (tick !== m_tick || time_bcd !== to_bcd(m_cs)) begin
                n_err++;
                $display("FAIL pause_resume_edge%0d: got %h tick=%b want %h tick=%b",
                         i + 1, time_bcd, tick, to_bcd(m_cs), m_tick);
            end
        end
        n_cmp++;
        if (time_bcd !== 16'h0001) begin
            n_err++;
            $display("FAIL pause_resume_time: got %h want 0001", time_bcd);
        end
    endtask

    task automatic test_wrap();
        drive(0, 1, 0);
        for (int i = 0; i < 59990; i++) begin
            drive(0, 0, 1);
            if (m_tick && (m_cs % 100 == 0)) begin
                n_cmp++;
                if (time_bcd !== to_bcd(m_cs)) begin
                    n_err++;
                    $display("FAIL wrap_run_sec: got %h want %h", time_bcd, to_bcd(m_cs));
                end
            end
        end
        n_cmp++;
        if (time_bcd !== 16'h5999) begin
            n_err++;
            $display("FAIL wrap_at_5999: got %h want 5999", time_bcd);
        end
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 1);
            n_cmp++;
            if (tick !== (i == 9) || wrapped !== (i == 9)) begin
                n_err++;
                $display("FAIL wrap_edge%0d: got tick=%b wrapped=%b want %b %b",
                         i + 1, tick, wrapped, (i == 9), (i == 9));
            end
        end
        n_cmp++;
        if (time_bcd !== 16'h0000) begin
            n_err++;
            $display("FAIL wrap_time: got %h want 0000", time_bcd);
        end
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 1);
            n_cmp++;
            if (wrapped !== 1'b0) begin
                n_err++;
                $display("FAIL wrap_after_edge%0d: got wrapped=%b want 0", i + 1, wrapped);
            end
        end
        n_cmp++;
        if (time_bcd !== 16'h0001) begin
            n_err++;
            $display("FAIL wrap_continue: got %h want 0001", time_bcd);
        end
    endtask

    task automatic test_init_with_enable();
        drive(0, 1, 0);
        repeat (1237) drive(0, 0, 1);
        n_cmp++;
        if (time_bcd !== 16'h0123) begin
            n_err++;
            $display("FAIL init_setup: got %h want 0123", time_bcd);
        end
        drive(0, 1, 1);
        n_cmp++;
        if (time_bcd !== 16'h0000 || tick !== 1'b0) begin
            n_err++;
            $display("FAIL init_clear: got %h tick=%b want 0000 tick=0", time_bcd, tick);
        end
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 1);
            n_cmp++;
            if (tick !== (i == 9)) begin
                n_err++;
                $display("FAIL init_full_period_edge%0d: got tick=%b want %b", i + 1, tick, (i == 9));
            end
        end
        n_cmp++;
        if (time_bcd !== 16'h0001) begin
            n_err++;
            $display("FAIL init_after: got %h want 0001", time_bcd);
        end
    endtask

    task automatic test_reset_mid();
        drive(0, 1, 0);
        repeat (3423) drive(0, 0, 1);
        n_cmp++;
        if (time_bcd !== 16'h0342) begin
            n_err++;
            $display("FAIL rstmid_setup: got %h want 0342", time_bcd);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 1);
            n_cmp++;
            if (time_bcd !== 16'h0000 || tick !== 1'b0 || wrapped !== 1'b0) begin
                n_err++;
                $display("FAIL rstmid_cycle%0d: got %h tick=%b wrapped=%b want 0000 0 0",
                         i + 1, time_bcd, tick, wrapped);
            end
        end
        repeat (10) drive(0, 0, 1);
        n_cmp++;
        if (time_bcd !== 16'h0001) begin
            n_err++;
            $display("FAIL rstmid_restart: got %h want 0001", time_bcd);
        end
    endtask

    task automatic test_random();
        bit r;
        bit i;
        bit e;
        for (int k = 0; k < 3000; k++) begin
            r = ($urandom_range(0, 199) == 0);
            i = ($urandom_range(0, 99) == 0);
            e = ($urandom_range(0, 3) != 0);
            drive(r, i, e);
            n_cmp++;
            if (time_bcd !== to_bcd(m_cs) || tick !== m_tick || wrapped !== m_wrap) begin
                n_err++;
                $display("FAIL random_cycle%0d: got %h t=%b w=%b want %h t=%b w=%b",
                         k, time_bcd, tick, wrapped, to_bcd(m_cs), m_tick, m_wrap);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        n_cmp         = 0;
        n_err         = 0;
        m_cs          = 0;
        m_phase       = 0;
        m_tick        = 0;
        m_wrap        = 0;
        reset         = 1'b1;
        init_regs     = 1'b0;
        count_enabled = 1'b0;

        test_reset();
        test_first_tick();
        test_carry();
        test_pause();
        test_wrap();
        test_init_with_enable();
        test_reset_mid();
        test_random();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/stopwatch_counter.md
Name: stopwatch_counter

Overview:
Time-keeping datapath directly downstream of the stopwatch control FSM. It consumes init_regs and count_enabled and runs a clock prescaler plus a four-digit BCD cascade (SS.CC: seconds 00–59, centiseconds 00–99). It presents the packed BCD time to the display stage. It has no state machine of its own: the control FSM decides clear/run/hold, and this block only obeys.

Parameters:
CLK_FREQ, 100000000, input clock frequency in Hz.
TICK_HZ, 100, digit-increment rate in Hz (one centisecond).
DIV (localparam), CLK_FREQ/TICK_HZ, prescaler modulus. CLK_FREQ must be an exact multiple of TICK_HZ, and DIV must be >= 2. The prescaler is $clog2(DIV) bits wide.

Ports:
clk            input   1   system clock, all logic on rising edge
reset          input   1   synchronous, active-high; clears all state
init_regs      input   1   from control FSM; clear prescaler and digits
count_enabled  input   1   from control FSM; advance prescaler/digits
time_bcd       output  16  {sec_tens, sec_ones, csec_tens, csec_ones}, 4 bits each
tick           output  1   registered 1-cycle pulse, asserted on the edge the digits advance
wrapped        output  1   registered 1-cycle pulse, asserted on the edge 59.99 -> 00.00

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: time_bcd=16'h0000, tick=0, wrapped=0, prescaler=0.
- Priority per edge: reset > init_regs > count_enabled > hold.
- init_regs=1 (reset=0):
  - prescaler, digits, tick and wrapped all go to 0 on the next edge.
  - This holds regardless of count_enabled, so simultaneous init_regs and count_enabled means clear.
- Hold (init_regs=0, count_enabled=0):
  - Prescaler and digits keep their values, so a paused partial tick is preserved and resumes on re-enable.
  - tick=0 and wrapped=0.
- Count (count_enabled=1, init_regs=0):
  - If prescaler < DIV-1: prescaler increments, tick=0.
  - If prescaler == DIV-1: prescaler goes to 0, tick=1, and the digit cascade advances on the same edge.
  - From a cleared state, the first tick occurs on the DIV-th consecutive enabled edge.
- Digit cascade, all updated on the tick edge:
  - csec_ones 0..9: wraps 9->0 and carries.
  - csec_tens 0..9: advances only on carry in; wraps 9->0 and carries.
  - sec_ones 0..9: advances only on carry in; wraps 9->0 and carries.
  - sec_tens 0..5: advances only on carry in; wraps 5->0.
  - 59.99 -> 00.00 on a tick, with wrapped=1 on that edge. The counter keeps running after wrap.
- Digits never hold non-BCD values. Any illegal digit value (unreachable, defensive) is forced to 0 on the next tick.
- Latency: an output change is visible the cycle after the causing edge. There is no combinational path from the inputs to the outputs.
- Reset or init_regs mid-prescale discards the partial count; no tick is generated.

Test Plan:
Bench parameters for all scenarios: CLK_FREQ=10, TICK_HZ=1, so DIV=10.
1. Reset, then count_enabled=1 for 10 cycles -> tick pulses only on the 10th edge; time_bcd goes 16'h0000 -> 16'h0001.
2. Enable 95 cycles -> time_bcd=16'h0009. Enable 5 more -> 16'h0010 (carry csec_ones -> csec_tens).
3. Enable 4 cycles, deassert count_enabled for 20 cycles (time_bcd stays 16'h0000, tick=0), re-enable -> first tick after 6 more enabled edges.
4. Run to 16'h5999, then 10 more enabled edges -> time_bcd=16'h0000, with tick=1 and wrapped=1 on the same edge only. Continue 10 edges -> 16'h0001.
5. At 16'h0123 with prescaler=7: assert init_regs and count_enabled together for 1 cycle -> time_bcd=16'h0000, prescaler=0, no tick. A full 10 enabled edges are then needed for 16'h0001.
6. Assert reset while counting at 16'h0342 with init_regs=0 -> next edge time_bcd=16'h0000, tick=0, wrapped=0. Hold reset for 3 cycles with count_enabled=1 -> remains 16'h0000.
